// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, register-zero index and the MEM/WB writeback bundle.
package cpu_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              wr_en;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] alu_result;
    logic [ADDR_W-1:0] dest;
  } wb_bundle_t;
endpackage

// File: rtl/regfile_core.sv
// regfile_core: register storage with synchronous clear, one write port and two raw read ports.
module regfile_core
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] rdata2
);
  localparam int N = 2 ** AW;
  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] regs_d [N];
  always_comb begin
    for (int i = 0; i < N; i++)
      regs_d[i] = !rst ? '0 : (we && waddr == AW'(i)) ? wdata : regs_q[i];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
  end
  assign rdata1 = regs_q[raddr1];
  assign rdata2 = regs_q[raddr2];
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: writeback mux, commit gating, r0 masking, write-to-read bypass and commit counter.
module writeback_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WriteRegIn,
  input  logic              MemToRegIn,
  input  logic [DATA_W-1:0] dataMemoryDataIn,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [ADDR_W-1:0] registerIn,
  input  logic [ADDR_W-1:0] readReg1,
  input  logic [ADDR_W-1:0] readReg2,
  output logic [DATA_W-1:0] readData1,
  output logic [DATA_W-1:0] readData2,
  output logic [DATA_W-1:0] wbData,
  output logic [31:0]       wbCount
);
  wb_bundle_t wb;
  logic commit;
  logic [DATA_W-1:0] raw1, raw2;
  logic [31:0] wb_count_q, wb_count_d;
  assign wb = '{wr_en: WriteRegIn, mem_to_reg: MemToRegIn, mem_data: dataMemoryDataIn,
                alu_result: ALUResultIn, dest: registerIn};
  assign wbData = wb.mem_to_reg ? wb.mem_data : wb.alu_result;
  // Reset low suppresses both storage writes and bypass through this single term.
  assign commit = rst && wb.wr_en && (wb.dest != REG_ZERO);
  regfile_core #(.DW(DATA_W), .AW(ADDR_W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .we     (commit),
    .waddr  (wb.dest),
    .wdata  (wbData),
    .raddr1 (readReg1),
    .raddr2 (readReg2),
    .rdata1 (raw1),
    .rdata2 (raw2)
  );
  always_comb begin
    readData1 = (readReg1 == REG_ZERO) ? '0 :
                (BYPASS && commit && wb.dest == readReg1) ? wbData : raw1;
    readData2 = (readReg2 == REG_ZERO) ? '0 :
                (BYPASS && commit && wb.dest == readReg2) ? wbData : raw2;
    wb_count_d = !rst ? '0 : commit ? wb_count_q + 32'd1 : wb_count_q;
  end
  always_ff @(posedge clk) wb_count_q <= wb_count_d;
  assign wbCount = wb_count_q;
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: random and directed stimulus scored against an array-based architectural model.
module tb_writeback_regfile;
  logic clk = 0, rst = 0;
  logic we = 0, m2r = 0;
  logic [31:0] md = 0, alu = 0;
  logic [4:0] dst = 0, r1 = 0, r2 = 0;
  logic [31:0] rd1, rd2, wbd, cnt;

  typedef struct packed {
    logic [15:0] tag;
    logic [31:0] wb, d1, d2, c;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_regs [32];
  logic [31:0] model_cnt = 0;
  int total = 0, bad = 0;
  int tag = 0;

  always #5 clk = ~clk;

  writeback_regfile dut (
    .clk(clk), .rst(rst), .WriteRegIn(we), .MemToRegIn(m2r),
    .dataMemoryDataIn(md), .ALUResultIn(alu), .registerIn(dst),
    .readReg1(r1), .readReg2(r2), .readData1(rd1), .readData2(rd2),
    .wbData(wbd), .wbCount(cnt)
  );

  task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h expected=%h", nm, t, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("wbData", int'(e.tag), wbd, e.wb);
      chk("readData1", int'(e.tag), rd1, e.d1);
      chk("readData2", int'(e.tag), rd2, e.d2);
      chk("wbCount", int'(e.tag), cnt, e.c);
    end
  end

  function automatic logic [31:0] read_model(input logic [4:0] idx, input logic c, input logic [31:0] v);
    if (idx == 0) return 0;
    if (c && idx == dst) return v;
    return model_regs[idx];
  endfunction

  task automatic drive(input logic nrst, input logic w, input logic m, input logic [31:0] mdat,
                       input logic [31:0] adat, input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2);
    logic c;
    logic [31:0] v;
    exp_t e;
    rst = nrst; we = w; m2r = m; md = mdat; alu = adat; dst = d; r1 = a1; r2 = a2;
    v = m ? mdat : adat;
    c = nrst && w && (d != 0);
    e.tag = 16'(tag++);
    e.wb = v;
    e.d1 = read_model(a1, c, v);
    e.d2 = read_model(a2, c, v);
    e.c = model_cnt;
    sb.push_back(e);
    if (!nrst) begin
      foreach (model_regs[i]) model_regs[i] = 0;
      model_cnt = 0;
    end else if (c) begin
      model_regs[d] = v;
      model_cnt = model_cnt + 1;
    end
  endtask

  task automatic step(input logic nrst, input logic w, input logic m, input logic [31:0] mdat,
                      input logic [31:0] adat, input logic [4:0] d, input logic [4:0] a1, input logic [4:0] a2);
    @(posedge clk);
    #1;
    drive(nrst, w, m, mdat, adat, d, a1, a2);
  endtask

  initial begin
    foreach (model_regs[i]) model_regs[i] = 0;
    @(posedge clk);
    #1;
    step(0, 1, 0, 0, 32'h1234, 3, 3, 0);
    for (int i = 0; i < 16; i++) step(1, 0, 0, 0, 0, 0, 5'(2 * i), 5'(2 * i + 1));
    step(1, 1, 1, 2, 3, 4, 4, 0);
    step(1, 0, 1, 2, 3, 4, 4, 4);
    step(1, 1, 0, 0, 32'hDEADBEEF, 0, 0, 4);
    step(1, 0, 0, 0, 0, 0, 0, 4);
    step(1, 1, 1, 32'h11, 0, 7, 7, 7);
    step(1, 1, 1, 32'h22, 0, 7, 7, 7);
    step(1, 0, 0, 0, 0, 0, 7, 7);
    step(0, 1, 1, 32'h55, 0, 9, 9, 7);
    step(1, 0, 0, 0, 0, 0, 9, 7);
    @(posedge clk);
    #1;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    model_cnt = 32'hFFFF_FFFF;
    drive(1, 1, 0, 0, 32'hA5A5, 12, 12, 0);
    step(1, 0, 0, 0, 0, 0, 12, 0);
    for (int i = 0; i < 400; i++) begin
      logic [4:0] d, a1, a2;
      d = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      step($urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom, $urandom, d, a1, a2);
    end
    for (int i = 1; i < 32; i++) step(1, 0, 0, 0, 0, 0, 5'(i), 5'(32 - i));
    @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
